synth_spi_regs: RTL and testbench

SYNTH_SPI_REGS -- requirements
Module: synth_spi_regs

---
 rtl/synth_spi_regs.sv | 212 +++++++++++++++++++++
 tb/tb_synth_spi_regs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/synth_spi_regs.sv
// SPI-to-register bridge for a synth voice: eight byte registers loaded by 16-bit SPI frames.
// Optional macro SYNTH_SPI_READBACK_EN adds spi_miso read-back. The release register port is named release_ because "release" is a reserved word.
`timescale 1ns/1ps

module synth_spi_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_nss,
    output logic [15:0] osc_inc,
    output logic [7:0]  attack,
    output logic [7:0]  decay,
    output logic [7:0]  sustain,
    output logic [7:0]  release_,
    output logic [7:0]  volume,
    output logic [7:0]  ctrl,
    output logic        wr_stb,
    output logic        frame_err
`ifdef SYNTH_SPI_READBACK_EN
    ,
    output logic        spi_miso
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [2:0]  r_sclkSync;
    logic [1:0]  r_mosiSync;
    logic [1:0]  r_nssSync;
    logic        r_nssPrev;
    logic [4:0]  r_bitCnt;
    logic [15:0] r_shift;
    logic        r_frameDone;

    logic [15:0] r_oscInc;
    logic [7:0]  r_staging;
    logic [7:0]  r_attack;
    logic [7:0]  r_decay;
    logic [7:0]  r_sustain;
    logic [7:0]  r_release;
    logic [7:0]  r_volume;
    logic [7:0]  r_ctrl;
    logic        r_wrStb;
    logic        r_frameErr;

    logic        w_sclkRise;
    logic        w_sclkFall;
    logic        w_nss;
    logic        w_nssFall;
    logic        w_mosi;
    logic        w_lastBit;
    logic        w_rw;
    logic [3:0]  w_rsvd;
    logic [2:0]  w_addr;
    logic [7:0]  w_data;
    logic        w_writeOk;
    logic        w_frameBad;

    assign w_sclkRise = r_sclkSync[1] & ~r_sclkSync[2];
    assign w_sclkFall = ~r_sclkSync[1] & r_sclkSync[2];
    assign w_nss      = r_nssSync[1];
    assign w_nssFall  = r_nssPrev & ~w_nss;
    assign w_mosi     = r_mosiSync[1];
    assign w_lastBit  = (r_state == SHIFT) && w_sclkRise && !w_nss && (r_bitCnt == 5'd15);

    // Synchronizers reset to "nss low" so a frame only starts after nss has been seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclkSync <= '0;
            r_mosiSync <= '0;
            r_nssSync  <= '0;
            r_nssPrev  <= 1'b0;
        end else begin
            r_sclkSync <= {r_sclkSync[1:0], spi_clk};
            r_mosiSync <= {r_mosiSync[0], spi_mosi};
            r_nssSync  <= {r_nssSync[0], spi_nss};
            r_nssPrev  <= w_nss;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_nssFall) w_nextState = SHIFT;
            SHIFT: begin
                if (w_nss)          w_nextState = IDLE;
                else if (w_lastBit) w_nextState = HOLD;
            end
            HOLD:    if (w_nss) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_lastBit;
            if (r_state == IDLE && w_nssFall) begin
                r_bitCnt <= '0;
            end else if (r_state == SHIFT && !w_nss && w_sclkRise) begin
                r_shift  <= {r_shift[14:0], w_mosi};
                r_bitCnt <= r_bitCnt + 5'd1;
            end
        end
    end

    assign w_rw       = r_shift[15];
    assign w_rsvd     = r_shift[14:11];
    assign w_addr     = r_shift[10:8];
    assign w_data     = r_shift[7:0];
    assign w_writeOk  = r_frameDone && !w_rw && (w_rsvd == 4'd0);
    assign w_frameBad = r_frameDone && !w_rw && (w_rsvd != 4'd0);

    // Commit one cycle after the 16th bit; osc_inc only moves on the high-byte write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oscInc   <= 16'h0100;
            r_staging  <= 8'h00;
            r_attack   <= 8'h10;
            r_decay    <= 8'h10;
            r_sustain  <= 8'h80;
            r_release  <= 8'h20;
            r_volume   <= 8'hFF;
            r_ctrl     <= 8'h00;
            r_wrStb    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_wrStb    <= w_writeOk;
            r_frameErr <= w_frameBad;
            if (w_writeOk) begin
                case (w_addr)
                    3'd0: r_staging <= w_data;
                    3'd1: r_oscInc  <= {w_data, r_staging};
                    3'd2: r_attack  <= w_data;
                    3'd3: r_decay   <= w_data;
                    3'd4: r_sustain <= w_data;
                    3'd5: r_release <= w_data;
                    3'd6: r_volume  <= w_data;
                    3'd7: r_ctrl    <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign osc_inc   = r_oscInc;
    assign attack    = r_attack;
    assign decay     = r_decay;
    assign sustain   = r_sustain;
    assign release_  = r_release;
    assign volume    = r_volume;
    assign ctrl      = r_ctrl;
    assign wr_stb    = r_wrStb;
    assign frame_err = r_frameErr;

`ifdef SYNTH_SPI_READBACK_EN
    logic [7:0] w_readVal;
    logic [7:0] r_misoShift;
    logic       r_misoActive;

    // After 8 bits the header byte sits in r_shift[7:0].
    always_comb begin
        w_readVal = 8'h00;
        case (r_shift[2:0])
            3'd0: w_readVal = r_staging;
            3'd1: w_readVal = r_oscInc[15:8];
            3'd2: w_readVal = r_attack;
            3'd3: w_readVal = r_decay;
            3'd4: w_readVal = r_sustain;
            3'd5: w_readVal = r_release;
            3'd6: w_readVal = r_volume;
            3'd7: w_readVal = r_ctrl;
            default: w_readVal = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misoShift  <= '0;
            r_misoActive <= 1'b0;
        end else if (r_state != SHIFT) begin
            r_misoShift  <= '0;
            r_misoActive <= 1'b0;
        end else if (w_sclkFall && !w_nss) begin
            if (r_bitCnt == 5'd8 && r_shift[7]) begin
                r_misoShift  <= w_readVal;
                r_misoActive <= 1'b1;
            end else if (r_misoActive) begin
                r_misoShift <= {r_misoShift[6:0], 1'b0};
            end
        end
    end

    assign spi_miso = r_misoActive & r_misoShift[7] & (r_state == SHIFT);
`endif

endmodule

// File: tb/tb_synth_spi_regs.sv
// Directed bench for synth_spi_regs: bit-bangs SPI frames and checks registers and strobes.
// Define SYNTH_SPI_READBACK_EN to also exercise the spi_miso read-back path.
`timescale 1ns/1ps

module tb_synth_spi_regs;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_nss;
    logic [15:0] osc_inc;
    logic [7:0]  attack, decay, sustain, release_, volume, ctrl;
    logic        wr_stb;
    logic        frame_err;
`ifdef SYNTH_SPI_READBACK_EN
    logic        spi_miso;
`endif

    int     assertCount = 0;
    int     failCount   = 0;
    int     stbPulses   = 0;
    int     stbCycles   = 0;
    int     errPulses   = 0;
    int     errCycles   = 0;
    logic   prevStb     = 1'b0;
    logic   prevErr     = 1'b0;
    longint stbTime     = 0;
    longint t16         = 0;
    logic [7:0] misoCap = 8'h00;

    int p0, c0, ep0, ec0;

    synth_spi_regs dut (
        .clk       (clk),
        .rst       (rst),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_nss   (spi_nss),
        .osc_inc   (osc_inc),
        .attack    (attack),
        .decay     (decay),
        .sustain   (sustain),
        .release_  (release_),
        .volume    (volume),
        .ctrl      (ctrl),
        .wr_stb    (wr_stb),
        .frame_err (frame_err)
`ifdef SYNTH_SPI_READBACK_EN
        ,
        .spi_miso  (spi_miso)
`endif
    );

    always #5 clk = ~clk;

    // Strobe monitor: counts pulses and high cycles, sampled on the inactive edge.
    always @(negedge clk) begin
        if (wr_stb === 1'b1) begin
            stbCycles <= stbCycles + 1;
            if (!prevStb) begin
                stbPulses <= stbPulses + 1;
                stbTime   <= $time;
            end
        end
        if (frame_err === 1'b1) begin
            errCycles <= errCycles + 1;
            if (!prevErr) errPulses <= errPulses + 1;
        end
        prevStb <= (wr_stb === 1'b1);
        prevErr <= (frame_err === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic spiBit(input logic b, input int idx);
        @(negedge clk) spi_mosi = b;
        repeat (HALF) @(negedge clk);
`ifdef SYNTH_SPI_READBACK_EN
        if (idx >= 8 && idx < 16) misoCap = {misoCap[6:0], spi_miso};
`endif
        spi_clk = 1'b1;
        if (idx == 15) t16 = $time;
        repeat (HALF) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [15:0] frame, input int nBits);
        logic b;
        @(negedge clk) spi_nss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nBits; i++) begin
            b = 1'b0;
            if (i < 16) b = frame[15 - i];
            spiBit(b, i);
        end
        repeat (10) @(negedge clk);
        spi_nss = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic snapshot();
        p0  = stbPulses;
        c0  = stbCycles;
        ep0 = errPulses;
        ec0 = errCycles;
    endtask

    initial begin
        logic [15:0] hdr;
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 1'b0;
        spi_nss  = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rstOscInc",  {16'h0, osc_inc}, 32'h0100);
        checkOutput("rstAttack",  {24'h0, attack},  32'h10);
        checkOutput("rstDecay",   {24'h0, decay},   32'h10);
        checkOutput("rstSustain", {24'h0, sustain}, 32'h80);
        checkOutput("rstRelease", {24'h0, release_}, 32'h20);
        checkOutput("rstVolume",  {24'h0, volume},  32'hFF);
        checkOutput("rstCtrl",    {24'h0, ctrl},    32'h00);
        checkOutput("rstWrStb",   {31'h0, wr_stb},  32'h0);
        checkOutput("rstFrameErr", {31'h0, frame_err}, 32'h0);
        checkOutput("rstNoPulses", stbPulses + errPulses, 0);

        $display("[TB] reset with nss held low");
        snapshot();
        @(negedge clk) spi_nss = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hdr = 16'h0299;
        for (int i = 0; i < 16; i++) spiBit(hdr[15 - i], i);
        repeat (10) @(negedge clk);
        spi_nss = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("nssLowAttack", {24'h0, attack}, 32'h10);
        checkOutput("nssLowNoStb", stbPulses - p0, 0);

        $display("[TB] reset mid-frame");
        snapshot();
        hdr = 16'h0611;
        @(negedge clk) spi_nss = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) spiBit(hdr[15 - i], i);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 10; i < 16; i++) spiBit(hdr[15 - i], i);
        repeat (10) @(negedge clk);
        spi_nss = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midRstVolume", {24'h0, volume}, 32'hFF);
        checkOutput("midRstNoStb", stbPulses - p0, 0);

        $display("[TB] write attack");
        snapshot();
        applyStimulus(16'h025A, 16);
        checkOutput("attackVal",   {24'h0, attack}, 32'h5A);
        checkOutput("attackPulse", stbPulses - p0, 1);
        checkOutput("attackWidth", stbCycles - c0, 1);
        checkOutput("attackLatency", {31'h0, (stbTime - t16) <= 45}, 32'h1);
        checkOutput("attackNoErr", errPulses - ep0, 0);

        $display("[TB] osc_inc staging");
        applyStimulus(16'h0034, 16);
        checkOutput("oscAfterLo", {16'h0, osc_inc}, 32'h0100);
        applyStimulus(16'h0112, 16);
        checkOutput("oscAfterHi", {16'h0, osc_inc}, 32'h1234);

        $display("[TB] aborted frame");
        snapshot();
        applyStimulus(16'h0600, 11);
        checkOutput("abortVolume", {24'h0, volume}, 32'hFF);
        checkOutput("abortNoStb",  stbPulses - p0, 0);
        checkOutput("abortNoErr",  errPulses - ep0, 0);

        $display("[TB] reserved bits set");
        snapshot();
        applyStimulus(16'h4877, 16);
        checkOutput("rsvdErrPulse", errPulses - ep0, 1);
        checkOutput("rsvdErrWidth", errCycles - ec0, 1);
        checkOutput("rsvdNoStb",    stbPulses - p0, 0);
        checkOutput("rsvdOscInc",   {16'h0, osc_inc}, 32'h1234);
        applyStimulus(16'h01AB, 16);
        checkOutput("rsvdStagingKept", {16'h0, osc_inc}, 32'hAB34);

        $display("[TB] 20 clocks in one frame");
        snapshot();
        applyStimulus(16'h0440, 20);
        checkOutput("longSustain", {24'h0, sustain}, 32'h40);
        checkOutput("longOneWrite", stbPulses - p0, 1);
        checkOutput("longAttackKept", {24'h0, attack}, 32'h5A);

`ifdef SYNTH_SPI_READBACK_EN
        $display("[TB] read-back");
        applyStimulus(16'h07A5, 16);
        checkOutput("rbCtrlWritten", {24'h0, ctrl}, 32'hA5);
        snapshot();
        misoCap = 8'h00;
        applyStimulus(16'h8700, 16);
        checkOutput("rbMisoBits", {24'h0, misoCap}, 32'hA5);
        checkOutput("rbCtrlKept", {24'h0, ctrl}, 32'hA5);
        checkOutput("rbNoStb",    stbPulses - p0, 0);
        checkOutput("rbMisoIdle", {31'h0, spi_miso}, 32'h0);
`else
        $display("[TB] read frame ignored");
        snapshot();
        applyStimulus(16'h8255, 16);
        checkOutput("rdAttackKept", {24'h0, attack}, 32'h5A);
        checkOutput("rdNoStb", stbPulses - p0, 0);
        checkOutput("rdNoErr", errPulses - ep0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
